mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of cycles one memory access waits for MemReady.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the retired-instruction counter.
REQ-003 SHALL have the following ports:
- CLK  in  1  single clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- OpCode  in  6  instruction opcode, taken from the instruction register.
- Funct  in  6  R-type function field.
- ALUZero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite, PCWriteCond, IorD, IRWrite  out  1 each  PC and instruction-register controls.
- MemRead, MemWrite, Mem2Reg, RegDst, RegWrite, ExtOp, ALUSrcA  out  1 each  datapath controls.
- ALUSrcB  out  2  00 rt, 01 constant 4, 10 extended immediate, 11 extended immediate<<2.
- PCSource  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- ALUOp  out  2  00 add, 01 sub, 10 decode Funct, 11 or.
- State  out  4  current FSM state.
- Illegal, MemErr  out  1 each  sticky trap causes.
- InstrCount  out  CNT_W  retired instructions (present only under the macro).

Function
REQ-004 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, TRAP=12; codes 13-15 SHALL go to TRAP.
REQ-005 FETCH SHALL assert MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01 and ALUOp=00; IRWrite and PCWrite SHALL be asserted only in the cycle MemReady=1; the FSM SHALL then go to DECODE.
REQ-006 DECODE SHALL assert ALUSrcA=0, ALUSrcB=11, ALUOp=00 and ExtOp=1, then dispatch on OpCode:
- 000000 -> EXEC
- 100011 (lw) -> MEMADR
- 101011 (sw) -> MEMADR
- 000100 (beq) -> BRANCH
- 000010 (j) -> JUMP
- 001001 (addiu) -> IEXEC
- 001101 (ori) -> IEXEC
- any other opcode -> TRAP, and Illegal is set.
REQ-007 MEMADR SHALL assert ALUSrcA=1, ALUSrcB=10, ALUOp=00 and ExtOp=1; it SHALL go to MEMRD for lw and to MEMWR for sw.
REQ-008 MEMRD SHALL assert MemRead and IorD=1, then go to MEMWB on MemReady; MEMWB SHALL assert RegWrite, Mem2Reg=1 and RegDst=0, then go to FETCH.
REQ-009 MEMWR SHALL assert MemWrite and IorD=1, then go to FETCH on MemReady.
REQ-010 EXEC SHALL assert ALUSrcA=1, ALUSrcB=00 and ALUOp=10; RWB SHALL assert RegWrite, RegDst=1 and Mem2Reg=0, then go to FETCH.
REQ-011 BRANCH SHALL assert ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond and PCSource=01, then go to FETCH.
REQ-012 JUMP SHALL assert PCWrite and PCSource=10, then go to FETCH.
REQ-013 IEXEC SHALL assert ALUSrcA=1 and ALUSrcB=10, with ExtOp=1 and ALUOp=00 for addiu, or ExtOp=0 and ALUOp=11 for ori; IWB SHALL assert RegWrite, RegDst=0 and Mem2Reg=0, then go to FETCH.
REQ-014 Every output not listed for a state SHALL be 0.
REQ-015 A wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and increment on each cycle spent waiting with MemReady=0.
REQ-016 If the wait counter reaches MEM_TIMEOUT-1 while MemReady=0, the next state SHALL be TRAP and MemErr SHALL be set.
REQ-017 MemReady=1 in the timeout cycle SHALL take priority, completing the access with no trap.
REQ-018 TRAP SHALL deassert all controls and SHALL be left only by reset.
REQ-019 Illegal and MemErr SHALL stay set until reset.
REQ-020 Instruction latencies, counted in cycles with zero memory wait, SHALL be: lw 5, sw 4, R-type 4, addiu/ori 4, beq 3, j 3.

Reset
REQ-021 While RST=0 the FSM SHALL be forced to FETCH, and the wait counter, Illegal, MemErr and InstrCount SHALL be cleared immediately, independent of CLK.
REQ-022 While RST=0 all control outputs SHALL be 0 (FETCH outputs gated).
REQ-023 Reset asserted in the middle of an instruction SHALL abandon it with no write enable asserted.
REQ-024 The first FETCH SHALL begin on the first CLK edge after RST rises.

Configuration
REQ-025 With macro MIPS_PERF_CNT_EN defined, InstrCount SHALL exist and increment by 1, wrapping modulo 2^CNT_W, on every transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP or IWB.
REQ-026 Without MIPS_PERF_CNT_EN, the InstrCount port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-027 Reset then OpCode=000000, MemReady held 1 -> State 0,1,6,7,0; RegWrite=1 and RegDst=1 only in State 7.
REQ-028 lw with MemReady low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with Mem2Reg=1; total 8 cycles; no trap.
REQ-029 MEM_TIMEOUT=4 and MemReady held 0 in FETCH -> State 12 after 4 FETCH cycles; MemErr=1; IRWrite never asserted.
REQ-030 OpCode=111111 at DECODE -> State 12 and Illegal=1; RST low for 1 cycle -> State 0 and both flags 0.
REQ-031 beq with ALUZero=1 -> PCWriteCond=1 and PCSource=01 in State 8; with MIPS_PERF_CNT_EN, InstrCount goes 0->1, and CNT_W=4 after 16 instructions wraps to 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM with memory-wait timeout and sticky trap flags.
// Define MIPS_PERF_CNT_EN to add the InstrCount retired-instruction counter.
module mips_multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] OpCode,
   input  logic [5:0] Funct,
   input  logic       ALUZero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       IRWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       Mem2Reg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ExtOp,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [1:0] ALUOp,
   output logic [3:0] State,
   output logic       Illegal,
   output logic       MemErr
`ifdef MIPS_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] InstrCount
`endif
);

   localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

   localparam logic [5:0] OpRType = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpAddiu = 6'b001001;
   localparam logic [5:0] OpOri   = 6'b001101;

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExec   = 4'd6,
      StRwb    = 4'd7,
      StBranch = 4'd8,
      StJump   = 4'd9,
      StIExec  = 4'd10,
      StIWb    = 4'd11,
      StTrap   = 4'd12
   } stateT;

   stateT             stateQ, stateD;
   logic [WaitW-1:0]  waitCntQ, waitCntD;
   logic              illegalQ, memErrQ;
   logic              illegalSet, memErrSet;
   logic              timeout;
   logic              waitState;

   // Funct is decoded by the ALU control and ALUZero is gated in the datapath.
   logic unusedInputs;
   assign unusedInputs = ^{Funct, ALUZero};

   assign timeout   = (waitCntQ == WaitW'(MEM_TIMEOUT - 1));
   assign waitState = (stateQ == StFetch) || (stateQ == StMemRd) || (stateQ == StMemWr);

   always_comb begin
      stateD      = stateQ;
      illegalSet  = 1'b0;
      memErrSet   = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      IRWrite     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      Mem2Reg     = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ExtOp       = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      ALUOp       = 2'b00;

      case (stateQ)
         StFetch: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            if (MemReady) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               stateD  = StDecode;
            end else if (timeout) begin
               stateD    = StTrap;
               memErrSet = 1'b1;
            end
         end
         StDecode: begin
            ALUSrcB = 2'b11;
            ExtOp   = 1'b1;
            case (OpCode)
               OpRType:        stateD = StExec;
               OpLw, OpSw:     stateD = StMemAdr;
               OpBeq:          stateD = StBranch;
               OpJ:            stateD = StJump;
               OpAddiu, OpOri: stateD = StIExec;
               default: begin
                  stateD     = StTrap;
                  illegalSet = 1'b1;
               end
            endcase
         end
         StMemAdr: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ExtOp   = 1'b1;
            stateD  = (OpCode == OpSw) ? StMemWr : StMemRd;
         end
         StMemRd: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (MemReady) begin
               stateD = StMemWb;
            end else if (timeout) begin
               stateD    = StTrap;
               memErrSet = 1'b1;
            end
         end
         StMemWb: begin
            RegWrite = 1'b1;
            Mem2Reg  = 1'b1;
            stateD   = StFetch;
         end
         StMemWr: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (MemReady) begin
               stateD = StFetch;
            end else if (timeout) begin
               stateD    = StTrap;
               memErrSet = 1'b1;
            end
         end
         StExec: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            stateD  = StRwb;
         end
         StRwb: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
            stateD   = StFetch;
         end
         StBranch: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            stateD      = StFetch;
         end
         StJump: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            stateD   = StFetch;
         end
         StIExec: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            if (OpCode == OpOri) begin
               ALUOp = 2'b11;
            end else begin
               ExtOp = 1'b1;
            end
            stateD = StIWb;
         end
         StIWb: begin
            RegWrite = 1'b1;
            stateD   = StFetch;
         end
         StTrap: begin
            stateD = StTrap;
         end
         default: stateD = StTrap;
      endcase

      // Any state change clears the counter, so each memory access starts from zero.
      waitCntD = waitCntQ;
      if (stateD != stateQ) begin
         waitCntD = '0;
      end else if (waitState && !MemReady) begin
         waitCntD = waitCntQ + WaitW'(1);
      end

      if (!RST) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IorD        = 1'b0;
         IRWrite     = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         Mem2Reg     = 1'b0;
         RegDst      = 1'b0;
         RegWrite    = 1'b0;
         ExtOp       = 1'b0;
         ALUSrcA     = 1'b0;
         ALUSrcB     = 2'b00;
         PCSource    = 2'b00;
         ALUOp       = 2'b00;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         stateQ   <= StFetch;
         waitCntQ <= '0;
         illegalQ <= 1'b0;
         memErrQ  <= 1'b0;
      end else begin
         stateQ   <= stateD;
         waitCntQ <= waitCntD;
         illegalQ <= illegalQ | illegalSet;
         memErrQ  <= memErrQ | memErrSet;
      end
   end

   assign State   = stateQ;
   assign Illegal = illegalQ;
   assign MemErr  = memErrQ;

`ifdef MIPS_PERF_CNT_EN
   logic             retire;
   logic [CNT_W-1:0] instrCntQ;

   assign retire = (stateD == StFetch) &&
                   (stateQ inside {StMemWb, StMemWr, StRwb, StBranch, StJump, StIWb});

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         instrCntQ <= '0;
      end else if (retire) begin
         instrCntQ <= instrCntQ + CNT_W'(1);
      end
   end

   assign InstrCount = instrCntQ;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle expected state, controls and flags.
module tb_mips_multicycle_ctrl;

   localparam int unsigned MemTo = 4;
   localparam int unsigned CntW  = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [5:0] OpCode = '0;
   logic [5:0] Funct = '0;
   logic       ALUZero = 1'b0;
   logic       MemReady = 1'b0;
   logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, Mem2Reg;
   logic       RegDst, RegWrite, ExtOp, ALUSrcA;
   logic [1:0] ALUSrcB, PCSource, ALUOp;
   logic [3:0] State;
   logic       Illegal, MemErr;
`ifdef MIPS_PERF_CNT_EN
   logic [CntW-1:0] InstrCount;
`endif

   mips_multicycle_ctrl #(
      .MEM_TIMEOUT(MemTo),
      .CNT_W      (CntW)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .OpCode     (OpCode),
      .Funct      (Funct),
      .ALUZero    (ALUZero),
      .MemReady   (MemReady),
      .PCWrite    (PCWrite),
      .PCWriteCond(PCWriteCond),
      .IorD       (IorD),
      .IRWrite    (IRWrite),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Mem2Reg    (Mem2Reg),
      .RegDst     (RegDst),
      .RegWrite   (RegWrite),
      .ExtOp      (ExtOp),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .PCSource   (PCSource),
      .ALUOp      (ALUOp),
      .State      (State),
      .Illegal    (Illegal),
      .MemErr     (MemErr)
`ifdef MIPS_PERF_CNT_EN
      ,
      .InstrCount (InstrCount)
`endif
   );

   always #5 CLK = ~CLK;

   // {PCWrite,PCWriteCond,IorD,IRWrite,MemRead,MemWrite,Mem2Reg,RegDst,RegWrite,ExtOp,
   //  ALUSrcA,ALUSrcB,PCSource,ALUOp}
   logic [16:0] obsCtrl;
   assign obsCtrl = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, Mem2Reg, RegDst,
                     RegWrite, ExtOp, ALUSrcA, ALUSrcB, PCSource, ALUOp};

   typedef struct {
      string           tag;
      logic [3:0]      st;
      logic [16:0]     ctrl;
      logic            ill;
      logic            merr;
      logic [CntW-1:0] cnt;
   } expT;

   expT             expQ[$];
   logic [CntW-1:0] expCnt = '0;
   int              nChecks = 0;
   int              nErrors = 0;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Control table written directly from the state descriptions.
   function automatic logic [16:0] ctrlFor(input int st, input logic ori, input logic rdy);
      logic [16:0] c;
      c = '0;
      case (st)
         0:  begin c[12] = 1'b1; c[5:4] = 2'b01; c[16] = rdy; c[13] = rdy; end
         1:  begin c[5:4] = 2'b11; c[7] = 1'b1; end
         2:  begin c[6] = 1'b1; c[5:4] = 2'b10; c[7] = 1'b1; end
         3:  begin c[12] = 1'b1; c[14] = 1'b1; end
         4:  begin c[8] = 1'b1; c[10] = 1'b1; end
         5:  begin c[11] = 1'b1; c[14] = 1'b1; end
         6:  begin c[6] = 1'b1; c[1:0] = 2'b10; end
         7:  begin c[8] = 1'b1; c[9] = 1'b1; end
         8:  begin c[6] = 1'b1; c[1:0] = 2'b01; c[15] = 1'b1; c[3:2] = 2'b01; end
         9:  begin c[16] = 1'b1; c[3:2] = 2'b10; end
         10: begin
            c[6] = 1'b1; c[5:4] = 2'b10;
            if (ori) c[1:0] = 2'b11;
            else c[7] = 1'b1;
         end
         11: c[8] = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   task automatic sampleCheck();
      expT e;
      if (expQ.size() == 0) begin
         checkEq("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = expQ.pop_front();
      checkEq({e.tag, ".state"}, 32'(State), 32'(e.st));
      checkEq({e.tag, ".ctrl"}, 32'(obsCtrl), 32'(e.ctrl));
      checkEq({e.tag, ".flags"}, 32'({Illegal, MemErr}), 32'({e.ill, e.merr}));
`ifdef MIPS_PERF_CNT_EN
      checkEq({e.tag, ".count"}, 32'(InstrCount), 32'(e.cnt));
`endif
   endtask

   // Called at a negedge; drives inputs, checks outputs of the current state, returns at next negedge.
   task automatic step(input string tag, input logic [5:0] op, input logic rdy, input logic zero,
                       input int st, input logic ill, input logic merr);
      expT e;
      OpCode   = op;
      MemReady = rdy;
      ALUZero  = zero;
      Funct    = 6'($urandom);
      e.tag  = tag;
      e.st   = 4'(st);
      e.ctrl = ctrlFor(st, op == 6'b001101, rdy);
      e.ill  = ill;
      e.merr = merr;
      e.cnt  = expCnt;
      expQ.push_back(e);
      #2 sampleCheck();
      @(negedge CLK);
   endtask

   // Asynchronous reset: checked 1 time unit after assertion, with no clock edge in between.
   task automatic doReset(input string tag);
      expT e;
      RST      = 1'b0;
      MemReady = 1'b1;
      expCnt   = '0;
      e.tag  = tag;
      e.st   = 4'd0;
      e.ctrl = '0;
      e.ill  = 1'b0;
      e.merr = 1'b0;
      e.cnt  = '0;
      expQ.push_back(e);
      #1 sampleCheck();
      @(negedge CLK);
      RST = 1'b1;
   endtask

   task automatic runInstr(input string nm, input logic [5:0] op, input logic zero,
                           input int a, input int b);
      step({nm, ".fetch"}, op, 1'b1, zero, 0, 1'b0, 1'b0);
      step({nm, ".decode"}, op, 1'b1, zero, 1, 1'b0, 1'b0);
      step({nm, ".s2"}, op, 1'b1, zero, a, 1'b0, 1'b0);
      if (b >= 0) step({nm, ".s3"}, op, 1'b1, zero, b, 1'b0, 1'b0);
      expCnt = expCnt + CntW'(1);
   endtask

   initial begin
      @(negedge CLK);
      doReset("reset0");

      runInstr("rtype", 6'b000000, 1'b0, 6, 7);

      // lw with three wait cycles; the fourth MEMRD cycle is the timeout cycle with MemReady=1
      step("lw.fetch", 6'b100011, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      step("lw.decode", 6'b100011, 1'b1, 1'b0, 1, 1'b0, 1'b0);
      step("lw.memadr", 6'b100011, 1'b1, 1'b0, 2, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step($sformatf("lw.wait%0d", i), 6'b100011, 1'b0, 1'b0, 3,
                                       1'b0, 1'b0);
      step("lw.memrd", 6'b100011, 1'b1, 1'b0, 3, 1'b0, 1'b0);
      step("lw.memwb", 6'b100011, 1'b1, 1'b0, 4, 1'b0, 1'b0);
      expCnt = expCnt + CntW'(1);

      runInstr("sw", 6'b101011, 1'b0, 2, 5);
      runInstr("addiu", 6'b001001, 1'b0, 10, 11);
      runInstr("ori", 6'b001101, 1'b0, 10, 11);
      runInstr("beq", 6'b000100, 1'b1, 8, -1);
      runInstr("j", 6'b000010, 1'b0, 9, -1);
      for (int i = 0; i < 9; i++) runInstr($sformatf("jloop%0d", i), 6'b000010, 1'b0, 9, -1);
      step("wrap.fetch", 6'b000000, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      // Reset in the middle of an R-type: no RegWrite from RWB
      step("mid.fetch", 6'b000000, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      step("mid.decode", 6'b000000, 1'b1, 1'b0, 1, 1'b0, 1'b0);
      step("mid.exec", 6'b000000, 1'b1, 1'b0, 6, 1'b0, 1'b0);
      doReset("mid.reset");

      // Fetch timeout
      for (int i = 0; i < 4; i++) step($sformatf("to.fetch%0d", i), 6'b000000, 1'b0, 1'b0, 0,
                                       1'b0, 1'b0);
      step("to.trap0", 6'b000000, 1'b1, 1'b0, 12, 1'b0, 1'b1);
      step("to.trap1", 6'b000000, 1'b1, 1'b0, 12, 1'b0, 1'b1);
      doReset("to.reset");

      // Illegal opcode
      step("ill.fetch", 6'b111111, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      step("ill.decode", 6'b111111, 1'b1, 1'b0, 1, 1'b0, 1'b0);
      step("ill.trap0", 6'b111111, 1'b1, 1'b0, 12, 1'b1, 1'b0);
      step("ill.trap1", 6'b000000, 1'b1, 1'b0, 12, 1'b1, 1'b0);
      doReset("ill.reset");

      runInstr("post", 6'b000000, 1'b0, 6, 7);
      step("post.fetch", 6'b000000, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule
